// File: rtl/cdma_req_split.sv
// cdma_req_split: splits DMA requests into sub-requests that never cross a
// 2^BOUNDARY_BITS-byte boundary, issues every chunk with last=1, and folds the
// per-chunk done pulses back into one s_done per original request with last=1.
// Optional statistics counters are built when CDMA_SPLIT_STATS_EN is defined.
module cdma_req_split #(
    parameter int unsigned ADDR_BITS     = 64,
    parameter int unsigned LEN_BITS      = 28,
    parameter int unsigned BOUNDARY_BITS = 12,
    parameter int unsigned CMPL_DEPTH    = 8
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [ADDR_BITS-1:0] s_paddr,
    input  logic [LEN_BITS-1:0]  s_len,
    input  logic                 s_last,
    output logic                 s_done,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [ADDR_BITS-1:0] m_paddr,
    output logic [LEN_BITS-1:0]  m_len,
    output logic                 m_last,
    input  logic                 m_done,
    output logic                 err_zero_len,
    output logic [31:0]          stat_req_cnt,
    output logic [31:0]          stat_chunk_cnt
);

    localparam int unsigned PTR_BITS = $clog2(CMPL_DEPTH);
    localparam int unsigned CNT_BITS = $clog2(CMPL_DEPTH) + 1;
    localparam int unsigned NCH_BITS = LEN_BITS + 1;
    localparam logic [NCH_BITS-1:0] BOUND = {{(NCH_BITS-1){1'b0}}, 1'b1} << BOUNDARY_BITS;

    typedef enum logic [0:0] {IDLE, SPLIT} state_t;

    state_t                state;
    state_t                state_nx;
    logic [LEN_BITS-1:0]   rem;

    // completion FIFO: {nchunks, last} per accepted request
    logic [NCH_BITS-1:0]   nch_mem [CMPL_DEPTH];
    logic                  last_mem [CMPL_DEPTH];
    logic [PTR_BITS-1:0]   wr_ptr;
    logic [PTR_BITS-1:0]   rd_ptr;
    logic [CNT_BITS-1:0]   count;
    logic [CNT_BITS-1:0]   count_nx;
    logic [NCH_BITS-1:0]   got;

    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  hs;
    logic                  last_chunk;
    logic                  full_nx;
    logic [NCH_BITS-1:0]   s_nchunks;
    logic [ADDR_BITS-1:0]  nx_addr;
    logic [LEN_BITS-1:0]   nx_rem;

    // Bytes up to the next boundary, clipped to what is left of the request.
    function automatic logic [LEN_BITS-1:0] chunk_len(
        input logic [BOUNDARY_BITS-1:0] low,
        input logic [LEN_BITS-1:0]      rem_v
    );
        logic [NCH_BITS-1:0] span;
        span = BOUND - {{(NCH_BITS-BOUNDARY_BITS){1'b0}}, low};
        if ({1'b0, rem_v} < span)
            return rem_v;
        else
            return span[LEN_BITS-1:0];
    endfunction

    assign m_last = m_valid;

    // Handshake decode, chunk count, FIFO occupancy and next-state logic.
    always_comb begin
        accept     = s_valid && s_ready;
        push       = accept && (s_len != '0);
        hs         = m_valid && m_ready;
        last_chunk = (rem == m_len);
        s_nchunks  = ({{(NCH_BITS-BOUNDARY_BITS){1'b0}}, s_paddr[BOUNDARY_BITS-1:0]}
                      + {1'b0, s_len} + (BOUND - NCH_BITS'(1))) >> BOUNDARY_BITS;
        pop        = m_done && (count != '0) && ((got + NCH_BITS'(1)) == nch_mem[rd_ptr]);

        count_nx = count;
        if (push && !pop)
            count_nx = count + CNT_BITS'(1);
        else if (pop && !push)
            count_nx = count - CNT_BITS'(1);
        full_nx = (count_nx == CNT_BITS'(CMPL_DEPTH));

        state_nx = state;
        if (state == IDLE && push)
            state_nx = SPLIT;
        else if (state == SPLIT && hs && last_chunk)
            state_nx = IDLE;

        nx_addr = m_paddr + ADDR_BITS'(m_len);
        nx_rem  = rem - m_len;
    end

    // Split FSM: registers s_ready and the outgoing chunk (address, length, valid).
    // s_ready is computed from next state and next occupancy so it equals
    // "IDLE and not full" of the registered state, one cycle after any pop.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state        <= IDLE;
            s_ready      <= 1'b0;
            m_valid      <= 1'b0;
            m_paddr      <= '0;
            m_len        <= '0;
            rem          <= '0;
            err_zero_len <= 1'b0;
        end else begin
            s_ready <= (state_nx == IDLE) && !full_nx;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (s_len == '0) begin
                            err_zero_len <= 1'b1;
                        end else begin
                            m_valid <= 1'b1;
                            m_paddr <= s_paddr;
                            m_len   <= chunk_len(s_paddr[BOUNDARY_BITS-1:0], s_len);
                            rem     <= s_len;
                        end
                    end
                end
                SPLIT: begin
                    if (hs) begin
                        if (last_chunk) begin
                            m_valid <= 1'b0;
                        end else begin
                            m_paddr <= nx_addr;
                            m_len   <= chunk_len(nx_addr[BOUNDARY_BITS-1:0], nx_rem);
                            rem     <= nx_rem;
                        end
                    end
                end
                default: ;
            endcase
            state <= state_nx;
        end
    end

    // Completion FIFO storage (no reset needed; validity tracked by count).
    always_ff @(posedge aclk) begin
        if (push) begin
            nch_mem[wr_ptr]  <= s_nchunks;
            last_mem[wr_ptr] <= s_last;
        end
    end

    // Completion FIFO control, per-head done counter and s_done pulse.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            got    <= '0;
            s_done <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_BITS'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_BITS'(1);
            count <= count_nx;
            if (m_done && (count != '0))
                got <= pop ? '0 : got + NCH_BITS'(1);
            s_done <= pop && last_mem[rd_ptr];
        end
    end

`ifdef CDMA_SPLIT_STATS_EN
    logic [31:0] req_cnt;
    logic [31:0] chunk_cnt;

    // Free-running statistics: accepted non-empty requests and issued chunks.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            req_cnt   <= '0;
            chunk_cnt <= '0;
        end else begin
            if (push)
                req_cnt <= req_cnt + 32'd1;
            if (hs)
                chunk_cnt <= chunk_cnt + 32'd1;
        end
    end

    assign stat_req_cnt   = req_cnt;
    assign stat_chunk_cnt = chunk_cnt;
`else
    assign stat_req_cnt   = '0;
    assign stat_chunk_cnt = '0;
`endif

endmodule

// File: tb/tb_cdma_req_split.sv
// Directed testbench for cdma_req_split with hand-computed expected values.
module tb_cdma_req_split;

    logic        aclk = 1'b0;
    logic        areset;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_paddr;
    logic [27:0] s_len;
    logic        s_last;
    logic        s_done;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_paddr;
    logic [27:0] m_len;
    logic        m_last;
    logic        m_done;
    logic        err_zero_len;
    logic [31:0] stat_req_cnt;
    logic [31:0] stat_chunk_cnt;

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned exp_req = 0;
    int unsigned exp_chunk = 0;

    always #5 aclk = ~aclk;

    cdma_req_split #(
        .ADDR_BITS(64),
        .LEN_BITS(28),
        .BOUNDARY_BITS(12),
        .CMPL_DEPTH(8)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_paddr(s_paddr),
        .s_len(s_len),
        .s_last(s_last),
        .s_done(s_done),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_paddr(m_paddr),
        .m_len(m_len),
        .m_last(m_last),
        .m_done(m_done),
        .err_zero_len(err_zero_len),
        .stat_req_cnt(stat_req_cnt),
        .stat_chunk_cnt(stat_chunk_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send_req(input logic [63:0] pa, input logic [27:0] ln, input logic lst);
        int unsigned n = 0;
        @(negedge aclk);
        while (!s_ready && n < 40) begin
            @(negedge aclk);
            n++;
        end
        chk("s_ready_wait", {63'b0, s_ready}, 64'd1);
        s_valid = 1'b1;
        s_paddr = pa;
        s_len   = ln;
        s_last  = lst;
        @(posedge aclk);
        #1 s_valid = 1'b0;
        if (ln != 28'd0)
            exp_req++;
    endtask

    task automatic get_chunk(input logic [63:0] ea, input logic [27:0] el, output int unsigned n);
        n = 0;
        @(negedge aclk);
        while (!m_valid && n < 40) begin
            @(negedge aclk);
            n++;
        end
        chk("m_valid", {63'b0, m_valid}, 64'd1);
        chk("m_paddr", m_paddr, ea);
        chk("m_len", {36'b0, m_len}, {36'b0, el});
        chk("m_last", {63'b0, m_last}, 64'd1);
        @(posedge aclk);
        #1;
        exp_chunk++;
    endtask

    task automatic pulse_done(output logic sd);
        @(negedge aclk);
        m_done = 1'b1;
        @(posedge aclk);
        #1 m_done = 1'b0;
        @(negedge aclk);
        sd = s_done;
    endtask

    task automatic check_stats(input string tag);
`ifdef CDMA_SPLIT_STATS_EN
        chk({tag, "_req"}, {32'b0, stat_req_cnt}, 64'(exp_req));
        chk({tag, "_chunk"}, {32'b0, stat_chunk_cnt}, 64'(exp_chunk));
`else
        chk({tag, "_req"}, {32'b0, stat_req_cnt}, 64'd0);
        chk({tag, "_chunk"}, {32'b0, stat_chunk_cnt}, 64'd0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: sim time exceeded, got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned n;
        logic        sd;
        logic        lst;
        areset  = 1'b1;
        s_valid = 1'b0;
        s_paddr = '0;
        s_len   = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        m_done  = 1'b0;
        #1;
        chk("rst_s_ready", {63'b0, s_ready}, 64'd0);
        chk("rst_m_valid", {63'b0, m_valid}, 64'd0);
        chk("rst_m_paddr", m_paddr, 64'd0);
        chk("rst_m_len", {36'b0, m_len}, 64'd0);
        chk("rst_s_done", {63'b0, s_done}, 64'd0);
        chk("rst_err", {63'b0, err_zero_len}, 64'd0);
        check_stats("rst_stat");
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;

        // 1: boundary-crossing request, two chunks, one s_done
        send_req(64'h1F00, 28'h300, 1'b1);
        get_chunk(64'h1F00, 28'h100, n);
        chk("t1_first_latency", 64'(n), 64'd0);
        get_chunk(64'h2000, 28'h200, n);
        chk("t1_back_to_back", 64'(n), 64'd0);
        @(negedge aclk);
        chk("t1_m_valid_off", {63'b0, m_valid}, 64'd0);
        chk("t1_s_ready_back", {63'b0, s_ready}, 64'd1);
        pulse_done(sd);
        chk("t1_done1", {63'b0, sd}, 64'd0);
        pulse_done(sd);
        chk("t1_done2", {63'b0, sd}, 64'd1);
        @(negedge aclk);
        chk("t1_done_pulse_end", {63'b0, s_done}, 64'd0);

        // 2: aligned 12 KB request, last=0 -> no s_done
        send_req(64'h0, 28'h3000, 1'b0);
        get_chunk(64'h0, 28'h1000, n);
        get_chunk(64'h1000, 28'h1000, n);
        get_chunk(64'h2000, 28'h1000, n);
        for (int i = 0; i < 3; i++) begin
            pulse_done(sd);
            chk("t2_no_done", {63'b0, sd}, 64'd0);
        end
        pulse_done(sd);
        chk("t2_empty_stray_done", {63'b0, sd}, 64'd0);

        // 3: backpressure on a 4-chunk request, m_ready toggling
        @(negedge aclk);
        m_ready = 1'b0;
        send_req(64'h3800, 28'h3000, 1'b1);
        for (int k = 0; k < 4; k++) begin
            logic [63:0] ea;
            logic [27:0] el;
            ea = (k == 0) ? 64'h3800 : 64'h3000 + 64'(k) * 64'h1000;
            el = (k == 0 || k == 3) ? 28'h800 : 28'h1000;
            @(negedge aclk);
            chk("t3_valid", {63'b0, m_valid}, 64'd1);
            chk("t3_paddr", m_paddr, ea);
            chk("t3_len", {36'b0, m_len}, {36'b0, el});
            @(negedge aclk);
            chk("t3_paddr_hold", m_paddr, ea);
            chk("t3_len_hold", {36'b0, m_len}, {36'b0, el});
            chk("t3_valid_hold", {63'b0, m_valid}, 64'd1);
            m_ready = 1'b1;
            @(posedge aclk);
            #1 m_ready = 1'b0;
            exp_chunk++;
        end
        @(negedge aclk);
        chk("t3_valid_off", {63'b0, m_valid}, 64'd0);
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pulse_done(sd);
            chk("t3_no_early_done", {63'b0, sd}, 64'd0);
        end
        pulse_done(sd);
        chk("t3_done", {63'b0, sd}, 64'd1);

        // 4: fill the completion FIFO with 8 single-chunk requests
        for (int i = 0; i < 8; i++) begin
            lst = (i == 0) ? 1'b1 : 1'(i % 2);
            send_req(64'(i) * 64'h100, 28'h10, lst);
            get_chunk(64'(i) * 64'h100, 28'h10, n);
            @(negedge aclk);
            chk((i == 7) ? "t4_full_not_ready" : "t4_ready", {63'b0, s_ready}, (i == 7) ? 64'd0 : 64'd1);
        end
        pulse_done(sd);
        chk("t4_head_done", {63'b0, sd}, 64'd1);
        chk("t4_ready_after_pop", {63'b0, s_ready}, 64'd1);
        for (int i = 1; i < 8; i++) begin
            pulse_done(sd);
            chk("t4_drain_done", {63'b0, sd}, 64'(i % 2));
        end

        // 5: zero-length request is dropped and flagged
        send_req(64'h500, 28'h0, 1'b1);
        @(negedge aclk);
        chk("t5_no_valid", {63'b0, m_valid}, 64'd0);
        chk("t5_err", {63'b0, err_zero_len}, 64'd1);
        chk("t5_ready", {63'b0, s_ready}, 64'd1);
        send_req(64'h10, 28'h20, 1'b1);
        get_chunk(64'h10, 28'h20, n);
        @(negedge aclk);
        chk("t5_single_chunk", {63'b0, m_valid}, 64'd0);
        chk("t5_err_sticky", {63'b0, err_zero_len}, 64'd1);
        pulse_done(sd);
        chk("t5_done", {63'b0, sd}, 64'd1);
        check_stats("t5_stat");

        // 6: reset during chunk 2 of 3
        send_req(64'h0, 28'h3000, 1'b1);
        get_chunk(64'h0, 28'h1000, n);
        @(negedge aclk);
        chk("t6_chunk2_valid", {63'b0, m_valid}, 64'd1);
        chk("t6_chunk2_paddr", m_paddr, 64'h1000);
        areset = 1'b1;
        #1;
        chk("t6_rst_m_valid", {63'b0, m_valid}, 64'd0);
        chk("t6_rst_m_paddr", m_paddr, 64'd0);
        chk("t6_rst_m_len", {36'b0, m_len}, 64'd0);
        chk("t6_rst_s_ready", {63'b0, s_ready}, 64'd0);
        chk("t6_rst_err", {63'b0, err_zero_len}, 64'd0);
        chk("t6_rst_s_done", {63'b0, s_done}, 64'd0);
        exp_req   = 0;
        exp_chunk = 0;
        check_stats("t6_rst_stat");
        @(posedge aclk);
        #1 areset = 1'b0;
        pulse_done(sd);
        chk("t6_inflight_done_ignored", {63'b0, sd}, 64'd0);
        send_req(64'h1F00, 28'h300, 1'b1);
        get_chunk(64'h1F00, 28'h100, n);
        get_chunk(64'h2000, 28'h200, n);
        pulse_done(sd);
        chk("t6_done1", {63'b0, sd}, 64'd0);
        pulse_done(sd);
        chk("t6_done2", {63'b0, sd}, 64'd1);
        check_stats("t6_stat");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
